// File: rtl/apb_master.sv
// APB master: takes one command at a time through SETUP/ACCESS and returns a
// registered response, aborting with a timeout flag if PREADY never arrives.
module apb_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3} state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

   state_t      r_state, w_state_nx;
   logic        r_cmd_ready, w_cmd_ready_nx;
   logic        r_psel, w_psel_nx;
   logic        r_penable, w_penable_nx;
   logic        r_pwrite, w_pwrite_nx;
   logic [31:0] r_paddr, w_paddr_nx;
   logic [31:0] r_pdata, w_pdata_nx;
   logic        r_rsp_valid, w_rsp_valid_nx;
   logic [31:0] r_rsp_rdata, w_rsp_rdata_nx;
   logic        r_rsp_err, w_rsp_err_nx;
   logic        r_rsp_to, w_rsp_to_nx;
   logic [7:0]  r_cnt, w_cnt_nx;
   logic [7:0]  w_cnt_inc;

   assign w_cnt_inc = r_cnt + 8'd1;

   always_comb begin
      w_state_nx     = r_state;
      w_psel_nx      = r_psel;
      w_penable_nx   = r_penable;
      w_pwrite_nx    = r_pwrite;
      w_paddr_nx     = r_paddr;
      w_pdata_nx     = r_pdata;
      w_rsp_valid_nx = r_rsp_valid;
      w_rsp_rdata_nx = r_rsp_rdata;
      w_rsp_err_nx   = r_rsp_err;
      w_rsp_to_nx    = r_rsp_to;
      w_cnt_nx       = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_psel_nx    = 1'b0;
            w_penable_nx = 1'b0;
            if (cmd_valid && r_cmd_ready) begin
               w_pwrite_nx = cmd_write;
               w_paddr_nx  = cmd_addr;
               w_pdata_nx  = cmd_wdata;
               w_psel_nx   = 1'b1;
               w_state_nx  = S_SETUP;
            end
         end
         S_SETUP: begin
            w_penable_nx = 1'b1;
            w_cnt_nx     = 8'd0;
            w_state_nx   = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               w_psel_nx      = 1'b0;
               w_penable_nx   = 1'b0;
               w_rsp_valid_nx = 1'b1;
               w_rsp_err_nx   = PSLVERR;
               w_rsp_to_nx    = 1'b0;
               // Only a clean read returns bus data, so a floating PRDATA never leaks out
               w_rsp_rdata_nx = (!r_pwrite && !PSLVERR) ? PRDATA : 32'h0;
               w_state_nx     = S_RESP;
            end else begin
               w_cnt_nx = w_cnt_inc;
               if (w_cnt_inc == TO_LIM) begin
                  w_psel_nx      = 1'b0;
                  w_penable_nx   = 1'b0;
                  w_rsp_valid_nx = 1'b1;
                  w_rsp_err_nx   = 1'b1;
                  w_rsp_to_nx    = 1'b1;
                  w_rsp_rdata_nx = 32'h0;
                  w_state_nx     = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nx = 1'b0;
               w_state_nx     = S_IDLE;
            end
         end
         default: begin
            w_psel_nx      = 1'b0;
            w_penable_nx   = 1'b0;
            w_rsp_valid_nx = 1'b0;
            w_state_nx     = S_IDLE;
         end
      endcase
      // Registered ready follows the state we are entering, so it lags a handshake by one cycle
      w_cmd_ready_nx = (w_state_nx == S_IDLE) && !(r_state == S_IDLE && cmd_valid && r_cmd_ready);
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= 32'h0;
         r_pdata     <= 32'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
         r_rsp_to    <= 1'b0;
         r_cnt       <= 8'd0;
      end else begin
         r_state     <= w_state_nx;
         r_cmd_ready <= w_cmd_ready_nx;
         r_psel      <= w_psel_nx;
         r_penable   <= w_penable_nx;
         r_pwrite    <= w_pwrite_nx;
         r_paddr     <= w_paddr_nx;
         r_pdata     <= w_pdata_nx;
         r_rsp_valid <= w_rsp_valid_nx;
         r_rsp_rdata <= w_rsp_rdata_nx;
         r_rsp_err   <= w_rsp_err_nx;
         r_rsp_to    <= w_rsp_to_nx;
         r_cnt       <= w_cnt_nx;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PDATA       = r_pdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized transfers against a memory-backed slave model;
// expected response and timing are derived from wait count and error choice.
module tb_apb_master;

   localparam int TO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [logic [31:0]];

   apb_master #(.TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PDATA(PDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk1("cmd_ready_wait", cmd_ready, 1'b1);
   endtask

   // One complete transfer; waits >= TO means the slave never answers.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input bit serr, input int hold);
      bit          timed_out;
      int          acc;
      logic        exp_err, exp_to;
      logic [31:0] exp_rd, slave_rd;
      timed_out = (waits >= TO);
      acc       = timed_out ? TO : waits + 1;
      exp_err   = timed_out ? 1'b1 : serr;
      exp_to    = timed_out;
      slave_rd  = mem.exists(addr) ? mem[addr] : 32'h0;
      exp_rd    = (!timed_out && !wr && !serr) ? slave_rd : 32'h0;

      wait_ready();
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      tick();
      cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
      chk1("setup_psel", PSEL, 1'b1);
      chk1("setup_penable", PENABLE, 1'b0);
      chk("setup_paddr", PADDR, addr);
      chk1("setup_pwrite", PWRITE, wr);
      chk("setup_pdata", PDATA, wd);
      chk1("setup_cmd_ready", cmd_ready, 1'b0);
      // slave noise outside ACCESS must be ignored
      PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 'x;
      tick();
      for (int k = 0; k < acc; k++) begin
         chk1("acc_psel", PSEL, 1'b1);
         chk1("acc_penable", PENABLE, 1'b1);
         chk("acc_paddr", PADDR, addr);
         chk1("acc_pwrite", PWRITE, wr);
         chk("acc_pdata", PDATA, wd);
         chk1("acc_rsp_valid", rsp_valid, 1'b0);
         if (k == waits) begin
            PREADY = 1'b1; PSLVERR = serr; PRDATA = (wr || serr) ? 'x : slave_rd;
         end else begin
            PREADY = 1'b0; PSLVERR = $urandom; PRDATA = 'x;
         end
         tick();
      end
      PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 'x;
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk1("rsp_psel", PSEL, 1'b0);
      chk1("rsp_penable", PENABLE, 1'b0);
      chk1("rsp_err", rsp_err, exp_err);
      chk1("rsp_timeout", rsp_timeout, exp_to);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_wdata = 32'h0;
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         tick();
         chk1("hold_rsp_valid", rsp_valid, 1'b1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk1("hold_err", rsp_err, exp_err);
         chk1("hold_timeout", rsp_timeout, exp_to);
         chk1("hold_cmd_ready", cmd_ready, 1'b0);
         chk1("hold_psel", PSEL, 1'b0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0; cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
      chk1("done_rsp_valid", rsp_valid, 1'b0);
      chk1("done_cmd_ready", cmd_ready, 1'b1);
      chk1("done_psel", PSEL, 1'b0);
      chk("done_paddr_hold", PADDR, addr);
      if (wr && !serr && !timed_out) mem[addr] = wd;
   endtask

   initial begin
      PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; PRDATA = 'x; PREADY = 1'b1; PSLVERR = 1'b1;
      tick(); tick();
      chk1("rst_psel", PSEL, 1'b0);
      chk1("rst_penable", PENABLE, 1'b0);
      chk1("rst_pwrite", PWRITE, 1'b0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pdata", PDATA, 32'h0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk1("rst_err", rsp_err, 1'b0);
      chk1("rst_timeout", rsp_timeout, 1'b0);
      chk1("rst_cmd_ready", cmd_ready, 1'b0);
      PRESETn = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
      tick();
      chk1("rel_cmd_ready", cmd_ready, 1'b1);

      run_txn(1'b1, 32'h04, 32'hDEADBEEF, 0, 1'b0, 0);
      run_txn(1'b0, 32'h04, 32'h0, 3, 1'b0, 0);
      run_txn(1'b0, 32'h40, 32'h0, 0, 1'b1, 1);
      run_txn(1'b0, 32'h04, 32'h0, 999, 1'b0, 0);
      run_txn(1'b0, 32'h04, 32'h0, TO - 1, 1'b0, 0);
      run_txn(1'b1, 32'h08, 32'h12345678, 1, 1'b0, 5);

      // reset while in ACCESS drops the transfer with no response
      wait_ready();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'hA5A5A5A5;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk1("pre_rst_penable", PENABLE, 1'b1);
      PRESETn = 1'b0; PREADY = 1'b1;
      tick();
      chk1("mid_rst_psel", PSEL, 1'b0);
      chk1("mid_rst_penable", PENABLE, 1'b0);
      chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_paddr", PADDR, 32'h0);
      chk("mid_rst_pdata", PDATA, 32'h0);
      chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
      PRESETn = 1'b1; PREADY = 1'b0;
      tick();
      chk1("mid_rel_cmd_ready", cmd_ready, 1'b1);
      chk1("mid_rel_rsp_valid", rsp_valid, 1'b0);
      run_txn(1'b0, 32'h08, 32'h0, 2, 1'b0, 0);

      for (int t = 0; t < 25; t++) begin
         bit          wr;
         logic [31:0] a;
         int          w;
         wr = $urandom_range(0, 1);
         a  = 32'($urandom_range(0, 7)) << 2;
         w  = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(0, 4);
         run_txn(wr, a, $urandom, w, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
